activation_write_arbiter: RTL and testbench

Packet-level round-robin arbiter and write sequencer for the activation line-buffer write port. Sits between several AXI-stream activation sources and the activation buffer. It grants one stream per packet (held until TLAST), routes the beats to the line buffer chosen by that stream's register-file pointer, and generates the rotating one-hot bank write enables and the line address.

---
 rtl/activation_write_arbiter_pkg.sv | 8 +
 rtl/activation_write_arbiter_rr_arbiter.sv | 22 ++
 rtl/activation_write_arbiter.sv | 109 ++++++++++
 tb/tb_activation_write_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/activation_write_arbiter_pkg.sv
// NVP_v1_constants: activation-buffer geometry shared by the write path, plus the write-arbiter state type
package NVP_v1_constants;
  localparam int ACTIVATION_BANK_BIT_WIDTH = 16;
  localparam int ACTIVATION_BUFFER_BANK_COUNT = 4;
  localparam int ACTIVATION_LINE_BUFFER_DEPTH = 16;
  localparam int NUMBER_OF_ACTIVATION_LINE_BUFFERS = 8;
  typedef enum logic [1:0] {IDLE, STREAM, DROP} act_wr_arb_state_t;
endpackage

// File: rtl/activation_write_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching from the stream after last_winner
// Ports: req (request vector), last_winner (index of previous owner),
//        grant (one-hot pick, zero if no request), idx (binary index of the pick)
module rr_arbiter #(
  parameter int NUM_STREAMS = 3,
  localparam int SW = NUM_STREAMS > 1 ? $clog2(NUM_STREAMS) : 1
) (
  input  logic [NUM_STREAMS-1:0] req,
  input  logic [SW-1:0]          last_winner,
  output logic [NUM_STREAMS-1:0] grant,
  output logic [SW-1:0]          idx
);
  always_comb begin
    grant = '0;
    idx = '0;
    for (int i = NUM_STREAMS; i >= 1; i--)
      if (req[(int'(last_winner) + i) % NUM_STREAMS]) begin
        idx = SW'((int'(last_winner) + i) % NUM_STREAMS);
        grant = NUM_STREAMS'(1) << idx;
      end
  end
endmodule

// File: rtl/activation_write_arbiter.sv
// activation_write_arbiter: packet-level round-robin arbiter and bank-rotating write sequencer for the activation buffer
// Ports: clk/resetn (async active-low); s_* AXI-stream sources; i_stream_ptr target line buffer per stream;
//        i_enable gates new grants; i_bank_ready per-bank ready; o_wen/o_addr/o_data registered write port;
//        o_write_port_enable, o_grant, o_packet_done, o_overflow status.
// Option: ACT_WRITE_ARB_OVERFLOW_GUARD_EN adds overflow detection, the DROP state and sticky o_overflow;
//         without it line_addr silently wraps and writing continues.
module activation_write_arbiter
  import NVP_v1_constants::*;
#(
  parameter int NUM_STREAMS = 3,
  parameter int DATA_WIDTH = ACTIVATION_BANK_BIT_WIDTH,
  parameter int BANK_COUNT = ACTIVATION_BUFFER_BANK_COUNT,
  parameter int LB_DEPTH = ACTIVATION_LINE_BUFFER_DEPTH,
  parameter int NUM_LB = NUMBER_OF_ACTIVATION_LINE_BUFFERS,
  localparam int LB_SEL_W = $clog2(NUM_LB),
  localparam int ADDR_W = $clog2(LB_DEPTH)
) (
  input  logic                                   clk,
  input  logic                                   resetn,
  input  logic [NUM_STREAMS-1:0][DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_STREAMS-1:0]                 s_tvalid,
  input  logic [NUM_STREAMS-1:0]                 s_tlast,
  output logic [NUM_STREAMS-1:0]                 s_tready,
  input  logic [NUM_STREAMS-1:0][LB_SEL_W-1:0]   i_stream_ptr,
  input  logic                                   i_enable,
  input  logic [NUM_LB-1:0][BANK_COUNT-1:0]      i_bank_ready,
  output logic [NUM_LB-1:0][BANK_COUNT-1:0]      o_wen,
  output logic [ADDR_W-1:0]                      o_addr,
  output logic [DATA_WIDTH-1:0]                  o_data,
  output logic                                   o_write_port_enable,
  output logic [NUM_STREAMS-1:0]                 o_grant,
  output logic                                   o_packet_done,
  output logic                                   o_overflow
);
  localparam int SW = NUM_STREAMS > 1 ? $clog2(NUM_STREAMS) : 1;
  localparam int BW = BANK_COUNT > 1 ? $clog2(BANK_COUNT) : 1;
  act_wr_arb_state_t state_q, state_d;
  logic [NUM_STREAMS-1:0] pick;
  logic [SW-1:0] pick_idx, sel_q, last_q;
  logic [LB_SEL_W-1:0] ptr_q;
  logic [BW-1:0] bank_ptr;
  logic [ADDR_W-1:0] line_addr;
  logic open, start, accept, write, done, wrap, line_end, ovf;
  rr_arbiter #(.NUM_STREAMS(NUM_STREAMS)) u_rr (
    .req(s_tvalid), .last_winner(last_q), .grant(pick), .idx(pick_idx)
  );
  // DROP drains the owner unconditionally; STREAM needs the whole target line buffer ready
  assign open = state_q == DROP || (state_q == STREAM && &i_bank_ready[ptr_q]);
  assign s_tready = open ? NUM_STREAMS'(1) << sel_q : '0;
  assign start = state_q == IDLE && i_enable && |s_tvalid;
  assign accept = open && s_tvalid[sel_q];
  assign write = accept && state_q == STREAM;
  assign done = accept && s_tlast[sel_q];
  assign wrap = bank_ptr == BW'(BANK_COUNT - 1);
  assign line_end = line_addr == ADDR_W'(LB_DEPTH - 1);
`ifdef ACT_WRITE_ARB_OVERFLOW_GUARD_EN
  assign ovf = write && !done && wrap && line_end;
`else
  assign ovf = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    if (start) state_d = STREAM;
    else if (done) state_d = IDLE;
    else if (ovf) state_d = DROP;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      o_grant <= '0;
      sel_q <= '0;
      last_q <= SW'(NUM_STREAMS - 1);
      ptr_q <= '0;
      bank_ptr <= '0;
      line_addr <= '0;
      o_wen <= '0;
      o_addr <= '0;
      o_data <= '0;
      o_write_port_enable <= 1'b0;
      o_packet_done <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      o_wen <= '0;
      o_write_port_enable <= write;
      o_packet_done <= done;
      o_overflow <= o_overflow | ovf;
      if (start) begin
        o_grant <= pick;
        sel_q <= pick_idx;
        ptr_q <= i_stream_ptr[pick_idx];
      end
      if (done) begin
        o_grant <= '0;
        last_q <= sel_q;
        bank_ptr <= '0;
        line_addr <= '0;
      end else if (write) begin
        bank_ptr <= wrap ? '0 : bank_ptr + 1'b1;
        if (wrap) line_addr <= line_end ? '0 : line_addr + 1'b1;
      end
      if (write) begin
        o_wen[ptr_q][bank_ptr] <= 1'b1;
        o_addr <= line_addr;
        o_data <= s_tdata[sel_q];
      end
    end
  end
endmodule

// File: tb/tb_activation_write_arbiter.sv
// tb_activation_write_arbiter: table, directed and random checks against a beat-count reference model
module tb_activation_write_arbiter;
  localparam int NS = 3, DW = 16, BC = 4, D = 16, NL = 8, PW = 3, AW = 4;
`ifdef ACT_WRITE_ARB_OVERFLOW_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  logic clk = 1'b0, resetn = 1'b0;
  logic [NS-1:0][DW-1:0] s_tdata;
  logic [NS-1:0] s_tvalid, s_tlast, s_tready, o_grant;
  logic [NS-1:0][PW-1:0] i_stream_ptr;
  logic i_enable;
  logic [NL-1:0][BC-1:0] i_bank_ready, o_wen;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_data;
  logic o_write_port_enable, o_packet_done, o_overflow;
  always #5 clk = ~clk;
  activation_write_arbiter #(
    .NUM_STREAMS(NS), .DATA_WIDTH(DW), .BANK_COUNT(BC), .LB_DEPTH(D), .NUM_LB(NL)
  ) dut (
    .clk(clk), .resetn(resetn), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(s_tready), .i_stream_ptr(i_stream_ptr), .i_enable(i_enable),
    .i_bank_ready(i_bank_ready), .o_wen(o_wen), .o_addr(o_addr), .o_data(o_data),
    .o_write_port_enable(o_write_port_enable), .o_grant(o_grant),
    .o_packet_done(o_packet_done), .o_overflow(o_overflow)
  );
  int n_chk = 0, n_fail = 0, wr_cnt = 0;
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // Reference model: packet owner, latched pointer and beat count within the packet
  int m_st, m_own, m_last, m_n;
  logic [PW-1:0] m_ptr;
  bit m_ovf, m_acc;
  logic [NL-1:0][BC-1:0] e_wen;
  logic e_wpe, e_done;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  logic [NS-1:0] e_grant;
  task automatic model_reset();
    m_st = 0; m_own = 0; m_last = NS - 1; m_n = 0; m_ptr = '0; m_ovf = 0; m_acc = 0;
  endtask
  task automatic cycle();
    logic [NS-1:0] e_rdy;
    @(negedge clk);
    e_rdy = '0;
    if ((m_st == 1 && &i_bank_ready[m_ptr]) || m_st == 2) e_rdy[m_own] = 1'b1;
    chk("s_tready", s_tready, e_rdy);
    m_acc = m_st != 0 && s_tvalid[m_own] && e_rdy[m_own];
    e_wen = '0; e_wpe = 0; e_done = 0;
    if (m_st == 0) begin
      if (i_enable && |s_tvalid)
        for (int k = 1; k <= NS; k++)
          if (m_st == 0 && s_tvalid[(m_last + k) % NS]) begin
            m_own = (m_last + k) % NS;
            m_ptr = i_stream_ptr[m_own];
            m_st = 1;
            m_n = 0;
          end
    end else if (m_acc) begin
      if (m_st == 1) begin
        e_wen[m_ptr][m_n % BC] = 1'b1;
        e_addr = AW'((m_n / BC) % D);
        e_data = s_tdata[m_own];
        e_wpe = 1;
      end
      m_n++;
      if (s_tlast[m_own]) begin e_done = 1; m_last = m_own; m_st = 0; end
      else if (GUARD && m_n == BC * D) begin m_st = 2; m_ovf = 1; end
    end
    e_grant = m_st != 0 ? NS'(1) << m_own : '0;
    @(posedge clk);
    #1;
    chk("o_wen", o_wen, e_wen);
    chk("o_write_port_enable", o_write_port_enable, e_wpe);
    chk("o_packet_done", o_packet_done, e_done);
    chk("o_grant", o_grant, e_grant);
    chk("o_overflow", o_overflow, m_ovf);
    if (e_wpe) begin
      chk("o_addr", o_addr, e_addr);
      chk("o_data", o_data, e_data);
    end
    wr_cnt += int'(o_write_port_enable);
  endtask
  task automatic check_zero(string nm);
    chk({nm, "_wen"}, o_wen, 0);
    chk({nm, "_wpe"}, o_write_port_enable, 0);
    chk({nm, "_grant"}, o_grant, 0);
    chk({nm, "_done"}, o_packet_done, 0);
    chk({nm, "_ovf"}, o_overflow, 0);
    chk({nm, "_tready"}, s_tready, 0);
    chk({nm, "_addr"}, o_addr, 0);
    chk({nm, "_data"}, o_data, 0);
  endtask
  task automatic do_reset();
    resetn = 1'b0;
    model_reset();
    s_tvalid = '0; s_tlast = '0; s_tdata = '0; i_bank_ready = '1; i_enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    resetn = 1'b1;
  endtask
  task automatic send_pkt(int s, int n, int bp_at, int chg_at);
    int b = 0, cyc = 0, bp = 0;
    while (b < n && cyc < n * 4 + 20) begin
      s_tvalid = '0; s_tvalid[s] = 1'b1;
      s_tlast = '0; s_tlast[s] = b == n - 1;
      s_tdata[s] = DW'(16'hA0 + b);
      i_bank_ready = '1;
      if (b == bp_at && bp < 3) begin i_bank_ready[5][2] = 1'b0; bp++; end
      if (b == chg_at) i_stream_ptr[s] = 3'd2;
      cycle();
      cyc++;
      if (m_acc) b++;
    end
    chk("pkt_beats_accepted", b, n);
    s_tvalid = '0; s_tlast = '0; i_bank_ready = '1;
  endtask
  typedef struct {
    logic v, l;
    logic [BC-1:0] wen5;
    int addr;
    logic wpe, done;
    logic [NS-1:0] grant;
  } vec_t;
  vec_t tbl[10];
  initial begin
    int order[$];
    int sent[NS];
    logic [NS-1:0] pg;
    tbl[0] = '{1'b1, 1'b0, 4'b0000, 0, 1'b0, 1'b0, 3'b010};
    for (int i = 0; i < 8; i++)
      tbl[i + 1] = '{1'b1, i == 7, 4'b0001 << (i % 4), i / 4, 1'b1, i == 7, i == 7 ? 3'b000 : 3'b010};
    tbl[9] = '{1'b0, 1'b0, 4'b0000, 0, 1'b0, 1'b0, 3'b000};
    i_stream_ptr = '{3'd0, 3'd5, 3'd0};
    do_reset();
    for (int r = 0; r < 10; r++) begin
      s_tvalid = {1'b0, tbl[r].v, 1'b0};
      s_tlast = {1'b0, tbl[r].l, 1'b0};
      s_tdata[1] = DW'(16'hA0 + (r == 0 ? 0 : r - 1));
      cycle();
      chk("tbl_wen5", o_wen[5], tbl[r].wen5);
      chk("tbl_wen_other", o_wen & ~(32'hF << 20), 0);
      chk("tbl_wpe", o_write_port_enable, tbl[r].wpe);
      chk("tbl_done", o_packet_done, tbl[r].done);
      chk("tbl_grant", o_grant, tbl[r].grant);
      if (tbl[r].wpe) begin
        chk("tbl_addr", o_addr, AW'(tbl[r].addr));
        chk("tbl_data", o_data, DW'(16'hA0 + r - 1));
      end
    end
    do_reset();
    sent = '{0, 0, 0};
    pg = '0;
    for (int c = 0; c < 60 && order.size() < 6; c++) begin
      s_tvalid = '1;
      for (int s = 0; s < NS; s++) begin
        s_tlast[s] = sent[s] % 2 == 1;
        s_tdata[s] = DW'(s * 16 + sent[s]);
      end
      cycle();
      if (m_acc) sent[m_own]++;
      if (o_grant != 0 && pg == 0) order.push_back(int'(o_grant));
      pg = o_grant;
    end
    chk("fair_grants_seen", order.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < order.size()) chk("fair_order", order[i], 1 << (i % 3));
    s_tvalid = '0; s_tlast = '0;
    do_reset();
    i_stream_ptr[1] = 3'd5;
    wr_cnt = 0;
    send_pkt(1, 8, 3, -1);
    cycle();
    chk("bp_writes", wr_cnt, 8);
    do_reset();
    i_stream_ptr[1] = 3'd5;
    wr_cnt = 0;
    send_pkt(1, 8, -1, 3);
    i_enable = 1'b0;
    s_tvalid = '1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("disabled_grant", o_grant, 0);
    end
    chk("ptr_writes", wr_cnt, 8);
    s_tvalid = '0; i_enable = 1'b1;
    do_reset();
    i_stream_ptr[0] = 3'd3;
    wr_cnt = 0;
    send_pkt(0, 70, -1, -1);
    cycle();
    chk("ovf_writes", wr_cnt, GUARD ? 64 : 70);
    chk("ovf_flag", o_overflow, GUARD);
    chk("ovf_idle_grant", o_grant, 0);
    do_reset();
    i_stream_ptr[1] = 3'd5;
    begin
      int b = 0;
      for (int c = 0; c < 20 && b < 3; c++) begin
        s_tvalid = 3'b010; s_tlast = '0; s_tdata[1] = DW'(b);
        cycle();
        if (m_acc) b++;
      end
      chk("pre_reset_beats", b, 3);
    end
    resetn = 1'b0;
    #1;
    check_zero("midrst");
    do_reset();
    s_tvalid = '1; s_tlast = '0;
    cycle();
    chk("post_reset_grant", o_grant, 3'b001);
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      s_tvalid = NS'($urandom);
      for (int s = 0; s < NS; s++) begin
        s_tlast[s] = $urandom_range(0, 3) == 0;
        s_tdata[s] = DW'($urandom);
      end
      for (int l = 0; l < NL; l++)
        for (int k = 0; k < BC; k++) i_bank_ready[l][k] = $urandom_range(0, 9) != 0;
      i_enable = $urandom_range(0, 7) != 0;
      if (c % 50 == 0)
        for (int s = 0; s < NS; s++) i_stream_ptr[s] = PW'($urandom);
      cycle();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
